// File: rtl/note_synth.sv
// Purpose: two-voice square-wave tone generator (melody + chord) with a 1-bit pulse-density mix.
// Latency: inputs registered (E0), note loaded with phase restart (E1), first rise HALF cycles later; audio_out lags the voices by 1.
// Backpressure: none; free-running streaming consumer, inputs sampled every cycle.
//
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   med_ma, low_ma, med_ch, low_ch   4-bit note codes (1..7 = do..ti, others = rest)
//   melody_sq, chord_sq              per-voice square waves
//   audio_out                        pulse-density mix of both voices
//   active                           high while either voice holds a non-rest note
module note_synth #(
    parameter int CLK_HZ = 100_000_000,
    parameter int CNT_W  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] med_ma,
    input  logic [3:0] low_ma,
    input  logic [3:0] med_ch,
    input  logic [3:0] low_ch,
    output logic       melody_sq,
    output logic       chord_sq,
    output logic       audio_out,
    output logic       active
);

    // Effective note encoding: {octave, code[2:0]}, octave 1 = low. Every rest
    // collapses onto code 0 so a rest never looks like a note change.
    localparam logic [3:0] REST = 4'd0;

    // Medium-octave half periods in clock cycles; the low octave is exactly double.
    localparam logic [CNT_W-1:0] HALF_DO  = CNT_W'(CLK_HZ / (2 * 262));
    localparam logic [CNT_W-1:0] HALF_RE  = CNT_W'(CLK_HZ / (2 * 294));
    localparam logic [CNT_W-1:0] HALF_MI  = CNT_W'(CLK_HZ / (2 * 330));
    localparam logic [CNT_W-1:0] HALF_FA  = CNT_W'(CLK_HZ / (2 * 349));
    localparam logic [CNT_W-1:0] HALF_SOL = CNT_W'(CLK_HZ / (2 * 392));
    localparam logic [CNT_W-1:0] HALF_LA  = CNT_W'(CLK_HZ / (2 * 440));
    localparam logic [CNT_W-1:0] HALF_TI  = CNT_W'(CLK_HZ / (2 * 494));

    logic [3:0]            med_ma_q;
    logic [3:0]            low_ma_q;
    logic [3:0]            med_ch_q;
    logic [3:0]            low_ch_q;

    // Index 0 = melody voice, index 1 = chord voice.
    logic [1:0][3:0]       eff_note;
    logic [1:0][3:0]       cur_note;
    logic [1:0][CNT_W-1:0] cnt;
    logic [1:0][CNT_W-1:0] half;
    logic [1:0]            sq;
    logic                  pwm_ph;

    // Medium code wins when valid, otherwise fall back to the low-octave code.
    function automatic logic [3:0] pick_note(input logic [3:0] med, input logic [3:0] low);
        logic [3:0] res;
        res = REST;
        if (!med[3] && (med[2:0] != 3'd0)) begin
            res = {1'b0, med[2:0]};
        end else if (!low[3] && (low[2:0] != 3'd0)) begin
            res = {1'b1, low[2:0]};
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] half_of(input logic [3:0] note);
        logic [CNT_W-1:0] base;
        case (note[2:0])
            3'd1:    base = HALF_DO;
            3'd2:    base = HALF_RE;
            3'd3:    base = HALF_MI;
            3'd4:    base = HALF_FA;
            3'd5:    base = HALF_SOL;
            3'd6:    base = HALF_LA;
            3'd7:    base = HALF_TI;
            default: base = '0;
        endcase
        return note[3] ? (base << 1) : base;
    endfunction

    always_comb begin
        eff_note    = '0;
        half        = '0;
        eff_note[0] = pick_note(med_ma_q, low_ma_q);
        eff_note[1] = pick_note(med_ch_q, low_ch_q);
        half[0]     = half_of(cur_note[0]);
        half[1]     = half_of(cur_note[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            med_ma_q  <= '0;
            low_ma_q  <= '0;
            med_ch_q  <= '0;
            low_ch_q  <= '0;
            cur_note  <= '0;
            cnt       <= '0;
            sq        <= '0;
            pwm_ph    <= 1'b0;
            audio_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            med_ma_q <= med_ma;
            low_ma_q <= low_ma;
            med_ch_q <= med_ch;
            low_ch_q <= low_ch;

            for (int v = 0; v < 2; v++) begin
                if (eff_note[v] != cur_note[v]) begin
                    // Any change, octave-only included, restarts the phase from low.
                    cur_note[v] <= eff_note[v];
                    cnt[v]      <= '0;
                    sq[v]       <= 1'b0;
                end else if (cur_note[v] == REST) begin
                    cnt[v] <= '0;
                    sq[v]  <= 1'b0;
                end else if (cnt[v] == half[v] - CNT_W'(1)) begin
                    cnt[v] <= '0;
                    sq[v]  <= ~sq[v];
                end else begin
                    cnt[v] <= cnt[v] + CNT_W'(1);
                end
            end

            // One voice high gives a 50% duty pulse train, i.e. half the level of both high.
            pwm_ph <= ~pwm_ph;
            case (sq)
                2'b00:   audio_out <= 1'b0;
                2'b11:   audio_out <= 1'b1;
                default: audio_out <= ~pwm_ph;
            endcase

            active <= (cur_note[0] != REST) || (cur_note[1] != REST);
        end
    end

    assign melody_sq = sq[0];
    assign chord_sq  = sq[1];

endmodule

// File: tb/tb_note_synth.sv
module tb_note_synth;

    localparam int CLK_HZ   = 1_000_000;
    localparam int H_LA     = 1136;   // 1e6 / 880
    localparam int H_LA_LOW = 2272;   // H_LA << 1
    localparam int H_DO     = 1908;   // 1e6 / 524
    localparam int H_SOL    = 1275;   // 1e6 / 784
    localparam int N_MIX    = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] med_ma;
    logic [3:0] low_ma;
    logic [3:0] med_ch;
    logic [3:0] low_ch;
    logic       melody_sq;
    logic       chord_sq;
    logic       audio_out;
    logic       active;

    int checks   = 0;
    int failures = 0;

    note_synth #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .med_ma    (med_ma),
        .low_ma    (low_ma),
        .med_ch    (med_ch),
        .low_ch    (low_ch),
        .melody_sq (melody_sq),
        .chord_sq  (chord_sq),
        .audio_out (audio_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    // Observe outputs 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ideal square wave k edges after the load edge (load edge itself is k = 0).
    function automatic logic sq_at(input int k, input int h);
        if (k < 0) return 1'b0;
        return ((k / h) % 2) == 1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; med_ma = 0; low_ma = 0; med_ch = 0; low_ch = 0;
        repeat (3) tick();
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL reset_melody got=%b exp=0", melody_sq); end
        checks++; if (chord_sq  !== 1'b0) begin failures++; $display("FAIL reset_chord got=%b exp=0", chord_sq); end
        checks++; if (audio_out !== 1'b0) begin failures++; $display("FAIL reset_audio got=%b exp=0", audio_out); end
        checks++; if (active    !== 1'b0) begin failures++; $display("FAIL reset_active got=%b exp=0", active); end
        rst = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            checks++;
            if ({melody_sq, chord_sq, audio_out, active} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d got=%b exp=0000", i, {melody_sq, chord_sq, audio_out, active});
                break;
            end
        end
    endtask

    task automatic test_la();
        med_ma = 6;
        tick();  // E0: note_q
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL la_active_e0 got=%b exp=0", active); end
        tick();  // E1: cur_note load, k = 0
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL la_load_sq got=%b exp=0", melody_sq); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL la_active_e1 got=%b exp=0", active); end
        tick();  // E2: k = 1
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL la_active_e2 got=%b exp=1", active); end
        for (int k = 1; k <= 4 * H_LA + 2; k++) begin
            if (k > 1) tick();
            checks++;
            if (melody_sq !== sq_at(k, H_LA) || chord_sq !== 1'b0) begin
                failures++;
                $display("FAIL la_wave k=%0d got=%b/%b exp=%b/0", k, melody_sq, chord_sq, sq_at(k, H_LA));
                break;
            end
        end
    endtask

    task automatic test_low_octave();
        int k_end;
        k_end = 3 * H_LA_LOW + 500;
        med_ma = 0; low_ma = 6;
        tick();  // E0
        tick();  // E1: octave change restarts phase
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL low_load_sq got=%b exp=0", melody_sq); end
        for (int k = 1; k <= k_end; k++) begin
            tick();
            checks++;
            if (melody_sq !== sq_at(k, H_LA_LOW)) begin
                failures++;
                $display("FAIL low_wave k=%0d got=%b exp=%b", k, melody_sq, sq_at(k, H_LA_LOW));
                break;
            end
        end
        med_ma = 6;  // medium wins while low is still 6
        tick();      // E0: old low tone still high mid-period
        checks++; if (melody_sq !== 1'b1) begin failures++; $display("FAIL low_pre_switch got=%b exp=1", melody_sq); end
        tick();      // E1: forced low on load
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL med_switch_sq got=%b exp=0", melody_sq); end
        for (int k = 1; k <= 3 * H_LA; k++) begin
            tick();
            checks++;
            if (melody_sq !== sq_at(k, H_LA)) begin
                failures++;
                $display("FAIL med_after_low k=%0d got=%b exp=%b", k, melody_sq, sq_at(k, H_LA));
                break;
            end
        end
    endtask

    task automatic test_chord_invalid();
        med_ch = 9; low_ch = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            checks++;
            if (chord_sq !== 1'b0 || active !== 1'b1) begin
                failures++;
                $display("FAIL chord_invalid cycle=%0d chord=%b active=%b exp chord=0 active=1", i, chord_sq, active);
                break;
            end
        end
        med_ma = 0; low_ma = 0;
        tick();  // E0
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL stop_active_e0 got=%b exp=1", active); end
        tick();  // E1: melody returns to rest
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL stop_sq got=%b exp=0", melody_sq); end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL stop_active_e1 got=%b exp=1", active); end
        tick();  // E2
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL stop_active_e2 got=%b exp=0", active); end
        checks++; if (audio_out !== 1'b0) begin failures++; $display("FAIL stop_audio got=%b exp=0", audio_out); end
        med_ch = 0;
    endtask

    task automatic test_back_to_back();
        med_ma = 6;
        tick();  // E0
        tick();  // E1, k = 0
        for (int k = 1; k <= H_LA + 500; k++) tick();
        checks++; if (melody_sq !== 1'b1) begin failures++; $display("FAIL b2b_pre got=%b exp=1", melody_sq); end
        med_ma = 5;  // one-cycle blip to fa and straight back to la
        tick();
        med_ma = 6;
        tick();      // cur_note = fa, forced low
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL b2b_blip_sq got=%b exp=0", melody_sq); end
        tick();      // cur_note = la again, k = 0
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL b2b_reload_sq got=%b exp=0", melody_sq); end
        for (int k = 1; k <= H_LA + 1; k++) begin
            tick();
            checks++;
            if (melody_sq !== sq_at(k, H_LA)) begin
                failures++;
                $display("FAIL b2b_wave k=%0d got=%b exp=%b", k, melody_sq, sq_at(k, H_LA));
                break;
            end
        end
    endtask

    task automatic test_reset_mid_tone();
        // Continues from test_back_to_back: la sounding, k = H_LA + 1.
        for (int k = H_LA + 2; k <= H_LA + 500; k++) tick();
        checks++; if (melody_sq !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", melody_sq); end
        rst = 1'b1;
        tick();
        checks++; if (melody_sq !== 1'b0) begin failures++; $display("FAIL rst_mid_sq got=%b exp=0", melody_sq); end
        checks++; if (active !== 1'b0) begin failures++; $display("FAIL rst_mid_active got=%b exp=0", active); end
        checks++; if (audio_out !== 1'b0) begin failures++; $display("FAIL rst_mid_audio got=%b exp=0", audio_out); end
        tick();
        tick();
        rst = 1'b0;
        tick();  // first non-reset edge: note_q reloads
        checks++; if (melody_sq !== 1'b0 || active !== 1'b0) begin failures++; $display("FAIL rst_release sq=%b active=%b exp 0/0", melody_sq, active); end
        tick();  // cur_note reload, k = 0
        for (int k = 1; k <= 2 * H_LA; k++) begin
            tick();
            checks++;
            if (melody_sq !== sq_at(k, H_LA)) begin
                failures++;
                $display("FAIL rst_resume k=%0d got=%b exp=%b", k, melody_sq, sq_at(k, H_LA));
                break;
            end
        end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL rst_resume_active got=%b exp=1", active); end
    endtask

    task automatic test_mix();
        logic em, ec, pm, pc, ea;
        int   hi_act, hi_exp, diff;
        bit   bad;
        rst = 1'b1; med_ma = 1; low_ma = 0; med_ch = 5; low_ch = 0;
        tick();
        tick();
        rst = 1'b0;
        pm = 1'b0; pc = 1'b0; hi_act = 0; hi_exp = 0; bad = 1'b0;
        for (int e = 0; e < N_MIX; e++) begin
            tick();  // edge e after release; both voices load at e = 1
            em = (e < 1) ? 1'b0 : sq_at(e - 1, H_DO);
            ec = (e < 1) ? 1'b0 : sq_at(e - 1, H_SOL);
            // pwm phase seen at edge e is e % 2; audio reflects the previous cycle's voices.
            if (pm && pc)       ea = 1'b1;
            else if (pm || pc)  ea = ((e % 2) == 0);
            else                ea = 1'b0;
            hi_exp += int'(ea);
            hi_act += int'(audio_out);
            if (!bad) begin
                checks++;
                if (melody_sq !== em || chord_sq !== ec || audio_out !== ea) begin
                    failures++;
                    bad = 1'b1;
                    $display("FAIL mix_cycle e=%0d got m=%b c=%b a=%b exp m=%b c=%b a=%b",
                             e, melody_sq, chord_sq, audio_out, em, ec, ea);
                end
            end
            pm = em;
            pc = ec;
        end
        diff = (hi_act > hi_exp) ? hi_act - hi_exp : hi_exp - hi_act;
        checks++;
        if (diff * 100 > hi_exp) begin
            failures++;
            $display("FAIL mix_density got=%0d exp=%0d (within 1%%)", hi_act, hi_exp);
        end
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL mix_active got=%b exp=1", active); end
    endtask

    initial begin
        test_reset();
        test_la();
        test_low_octave();
        test_chord_invalid();
        test_back_to_back();
        test_reset_mid_tone();
        test_mix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
